// File: rtl/csr_bus_arbiter.sv
// Two-master CSR bus arbiter: a strobe-only port A (SPI side) with a 1-deep pending slot
// that always wins, and a wait-request port B (host/debug) served when the slot is empty.
module csr_bus_arbiter #(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [A_WIDTH-1:0] a_address,
    input  logic               a_read,
    input  logic               a_write,
    input  logic [D_WIDTH-1:0] a_writedata,
    output logic [D_WIDTH-1:0] a_readdata,
    output logic               a_rd_done,
    output logic               a_overrun,
    input  logic               a_overrun_clr,
    input  logic [A_WIDTH-1:0] b_address,
    input  logic               b_read,
    input  logic               b_write,
    input  logic [D_WIDTH-1:0] b_writedata,
    output logic               b_waitrequest,
    output logic [D_WIDTH-1:0] b_readdata,
    output logic               b_readdatavalid,
    output logic [A_WIDTH-1:0] m_address,
    output logic               m_read,
    output logic               m_write,
    output logic [D_WIDTH-1:0] m_writedata,
    input  logic [D_WIDTH-1:0] m_readdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               slot_full;
    logic [A_WIDTH-1:0] slot_addr;
    logic [D_WIDTH-1:0] slot_data;
    logic               slot_wr;

    logic               a_strobe;
    logic               b_req;
    logic               bus_free;
    logic               issue_a;
    logic               issue_b;
    logic               slot_load;
    logic               overrun_set;

    // Arbitration, CSR bus drive and next state; no issue while reset is held so the
    // bus stays quiet, but b_waitrequest keeps following its plain equation.
    always_comb begin
        a_strobe      = a_read | a_write;
        b_req         = b_read | b_write;
        bus_free      = (state == IDLE) && !slot_full;
        issue_a       = !reset && (state == IDLE) && slot_full;
        issue_b       = !reset && bus_free && b_req;
        slot_load     = a_strobe && (!slot_full || issue_a);
        overrun_set   = (a_read && a_write) || (a_strobe && slot_full && !issue_a);
        b_waitrequest = b_req && !bus_free;

        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        state_next    = state;

        if (issue_a) begin
            m_address   = slot_addr;
            m_write     = slot_wr;
            m_read      = !slot_wr;
            m_writedata = slot_wr ? slot_data : '0;
            state_next  = slot_wr ? IDLE : RD_A;
        end else if (issue_b) begin
            m_address   = b_address;
            m_write     = b_write;
            m_read      = !b_write;
            m_writedata = b_write ? b_writedata : '0;
            state_next  = b_write ? IDLE : RD_B;
        end else if (state != IDLE) begin
            state_next  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A simultaneous read+write strobe is stored as a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full <= 1'b0;
            slot_addr <= '0;
            slot_data <= '0;
            slot_wr   <= 1'b0;
        end else if (slot_load) begin
            slot_full <= 1'b1;
            slot_addr <= a_address;
            slot_data <= a_write ? a_writedata : '0;
            slot_wr   <= a_write;
        end else if (issue_a) begin
            slot_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_overrun <= 1'b0;
        end else if (overrun_set) begin
            a_overrun <= 1'b1;
        end else if (a_overrun_clr) begin
            a_overrun <= 1'b0;
        end
    end

    // Read data returns the cycle after the strobe and is captured on the way back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_readdata      <= '0;
            a_rd_done       <= 1'b0;
            b_readdata      <= '0;
            b_readdatavalid <= 1'b0;
        end else begin
            a_rd_done       <= (state == RD_A);
            b_readdatavalid <= (state == RD_B);
            if (state == RD_A) begin
                a_readdata <= m_readdata;
            end
            if (state == RD_B) begin
                b_readdata <= m_readdata;
            end
        end
    end

endmodule

// File: tb/tb_csr_bus_arbiter.sv
// Directed bench for csr_bus_arbiter with a small CSR register-file model on the m_* bus.
module tb_csr_bus_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a_address;
    logic          a_read;
    logic          a_write;
    logic [DW-1:0] a_writedata;
    logic [DW-1:0] a_readdata;
    logic          a_rd_done;
    logic          a_overrun;
    logic          a_overrun_clr;
    logic [AW-1:0] b_address;
    logic          b_read;
    logic          b_write;
    logic [DW-1:0] b_writedata;
    logic          b_waitrequest;
    logic [DW-1:0] b_readdata;
    logic          b_readdatavalid;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [DW-1:0] m_writedata;
    logic [DW-1:0] m_readdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mem [32];
    logic [31:0]   mem_written = '0;

    always #5 clk = ~clk;

    csr_bus_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_read(a_read), .a_write(a_write),
        .a_writedata(a_writedata), .a_readdata(a_readdata), .a_rd_done(a_rd_done),
        .a_overrun(a_overrun), .a_overrun_clr(a_overrun_clr),
        .b_address(b_address), .b_read(b_read), .b_write(b_write),
        .b_writedata(b_writedata), .b_waitrequest(b_waitrequest),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata)
    );

    // Unwritten registers read back addr*0x11, except register 3 which holds 0x3C.
    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 5'd3) return 8'h3C;
        return DW'(a) * 8'h11;
    endfunction

    always @(posedge clk) begin
        if (m_write) begin
            mem[m_address]         <= m_writedata;
            mem_written[m_address] <= 1'b1;
        end
        if (m_read) m_readdata <= mem_written[m_address] ? mem[m_address] : init_val(m_address);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_address = '0; a_read = 0; a_write = 0; a_writedata = '0; a_overrun_clr = 0;
        b_address = '0; b_read = 0; b_write = 0; b_writedata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        b_read = 1'b1; b_address = 5'd6;
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_read got %b exp 0", m_read); end
        n_checks++; if (m_address !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_m_address got %h exp 00", m_address); end
        n_checks++; if (b_waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_waitreq got %b exp 0", b_waitrequest); end
        n_checks++; if ({a_rd_done, a_overrun, b_readdatavalid, m_write} !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_flags got %b exp 0000", {a_rd_done, a_overrun, b_readdatavalid, m_write}); end
        n_checks++; if ({a_readdata, b_readdata} !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_rdata got %h exp 0000", {a_readdata, b_readdata}); end
        tick();
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_a_write();
        tick(); a_write = 1; a_address = 5'd5; a_writedata = 8'hA5;
        @(negedge clk);
        n_checks++; if (m_write !== 1'b0) begin n_fail++; $display("[TB] FAIL aw_early got %b exp 0", m_write); end
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL aw_strobe got w%b r%b exp w1 r0", m_write, m_read); end
        n_checks++; if (m_address !== 5'h05 || m_writedata !== 8'hA5) begin n_fail++; $display("[TB] FAIL aw_bus got %h/%h exp 05/a5", m_address, m_writedata); end
        tick();
        @(negedge clk);
        n_checks++; if (m_write !== 1'b0 || m_address !== 5'd0) begin n_fail++; $display("[TB] FAIL aw_after got w%b a%h exp w0 a00", m_write, m_address); end
    endtask

    task automatic test_a_read();
        tick(); a_read = 1; a_address = 5'd3;
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_read !== 1'b1 || m_address !== 5'd3) begin n_fail++; $display("[TB] FAIL ar_strobe got r%b a%h exp r1 a03", m_read, m_address); end
        tick();
        @(negedge clk);
        n_checks++; if (a_rd_done !== 1'b0 || m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_wait got done%b r%b exp 0 0", a_rd_done, m_read); end
        tick();
        @(negedge clk);
        n_checks++; if (a_rd_done !== 1'b1 || a_readdata !== 8'h3C) begin n_fail++; $display("[TB] FAIL ar_done got %b/%h exp 1/3c", a_rd_done, a_readdata); end
        tick();
        @(negedge clk);
        n_checks++; if (a_rd_done !== 1'b0 || a_readdata !== 8'h3C) begin n_fail++; $display("[TB] FAIL ar_hold got %b/%h exp 0/3c", a_rd_done, a_readdata); end
    endtask

    task automatic test_b_arbitration();
        tick(); a_write = 1; a_address = 5'd7; a_writedata = 8'h11;
        tick(); idle_inputs(); b_read = 1; b_address = 5'd9;
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_address !== 5'd7) begin n_fail++; $display("[TB] FAIL arb_a_first got w%b a%h exp w1 a07", m_write, m_address); end
        n_checks++; if (b_waitrequest !== 1'b1) begin n_fail++; $display("[TB] FAIL arb_wait got %b exp 1", b_waitrequest); end
        tick();
        @(negedge clk);
        n_checks++; if (b_waitrequest !== 1'b0 || m_read !== 1'b1 || m_address !== 5'd9) begin n_fail++; $display("[TB] FAIL arb_b_accept got wr%b r%b a%h exp 0 1 09", b_waitrequest, m_read, m_address); end
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (b_readdatavalid !== 1'b0) begin n_fail++; $display("[TB] FAIL arb_rdv_early got %b exp 0", b_readdatavalid); end
        tick();
        @(negedge clk);
        n_checks++; if (b_readdatavalid !== 1'b1 || b_readdata !== 8'h99) begin n_fail++; $display("[TB] FAIL arb_rdv got %b/%h exp 1/99", b_readdatavalid, b_readdata); end
    endtask

    task automatic test_b_inflight();
        tick(); b_read = 1; b_address = 5'd2; a_read = 1; a_address = 5'd4;
        @(negedge clk);
        n_checks++; if (m_read !== 1'b1 || m_address !== 5'd2 || b_waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL infl_b got r%b a%h wr%b exp 1 02 0", m_read, m_address, b_waitrequest); end
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL infl_rdb got %b exp 0", m_read); end
        tick();
        @(negedge clk);
        n_checks++; if (m_read !== 1'b1 || m_address !== 5'd4) begin n_fail++; $display("[TB] FAIL infl_a_issue got r%b a%h exp 1 04", m_read, m_address); end
        n_checks++; if (b_readdatavalid !== 1'b1 || b_readdata !== 8'h22) begin n_fail++; $display("[TB] FAIL infl_b_data got %b/%h exp 1/22", b_readdatavalid, b_readdata); end
        tick();
        tick();
        @(negedge clk);
        n_checks++; if (a_rd_done !== 1'b1 || a_readdata !== 8'h44 || a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL infl_a_done got %b/%h ov%b exp 1/44 0", a_rd_done, a_readdata, a_overrun); end
    endtask

    task automatic test_overrun();
        tick(); b_read = 1; b_address = 5'd1; a_write = 1; a_address = 5'd10; a_writedata = 8'h55;
        tick(); idle_inputs(); a_write = 1; a_address = 5'd11; a_writedata = 8'h66;
        @(negedge clk);
        n_checks++; if (a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_pre got %b exp 0", a_overrun); end
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_address !== 5'd10 || m_writedata !== 8'h55) begin n_fail++; $display("[TB] FAIL ovr_first got w%b %h/%h exp 1 0a/55", m_write, m_address, m_writedata); end
        n_checks++; if (a_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_set got %b exp 1", a_overrun); end
        tick(); a_overrun_clr = 1;
        @(negedge clk);
        n_checks++; if (m_write !== 1'b0 || a_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL ovr_dropped got w%b ov%b exp 0 1", m_write, a_overrun); end
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_clr got %b exp 0", a_overrun); end
    endtask

    task automatic test_back_to_back();
        tick(); a_write = 1; a_address = 5'd12; a_writedata = 8'h12;
        tick(); a_address = 5'd13; a_writedata = 8'h13;
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_address !== 5'd12) begin n_fail++; $display("[TB] FAIL b2b_first got w%b a%h exp 1 0c", m_write, m_address); end
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_address !== 5'd13 || m_writedata !== 8'h13) begin n_fail++; $display("[TB] FAIL b2b_second got w%b %h/%h exp 1 0d/13", m_write, m_address, m_writedata); end
        n_checks++; if (a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_no_ovr got %b exp 0", a_overrun); end
    endtask

    task automatic test_rw_together();
        tick(); a_read = 1; a_write = 1; a_address = 5'd14; a_writedata = 8'hEE; a_overrun_clr = 1;
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_writedata !== 8'hEE) begin n_fail++; $display("[TB] FAIL rw_as_write got w%b r%b d%h exp 1 0 ee", m_write, m_read, m_writedata); end
        n_checks++; if (a_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL rw_ovr_set_wins got %b exp 1", a_overrun); end
        tick(); a_overrun_clr = 1;
        tick(); idle_inputs();
        @(negedge clk);
        n_checks++; if (a_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL rw_clr got %b exp 0", a_overrun); end
    endtask

    task automatic test_b_write_wins();
        tick(); b_read = 1; b_write = 1; b_address = 5'd15; b_writedata = 8'h77;
        @(negedge clk);
        n_checks++; if (m_write !== 1'b1 || m_read !== 1'b0 || m_writedata !== 8'h77 || b_waitrequest !== 1'b0) begin n_fail++; $display("[TB] FAIL bb_write got w%b r%b d%h wr%b exp 1 0 77 0", m_write, m_read, m_writedata, b_waitrequest); end
        tick(); b_write = 0;
        @(negedge clk);
        n_checks++; if (m_read !== 1'b1 || m_address !== 5'd15) begin n_fail++; $display("[TB] FAIL bb_read got r%b a%h exp 1 0f", m_read, m_address); end
        tick(); idle_inputs();
        tick();
        @(negedge clk);
        n_checks++; if (b_readdatavalid !== 1'b1 || b_readdata !== 8'h77) begin n_fail++; $display("[TB] FAIL bb_rdata got %b/%h exp 1/77", b_readdatavalid, b_readdata); end
    endtask

    task automatic test_reset_mid_read();
        tick(); a_read = 1; a_address = 5'd3;
        tick(); idle_inputs();
        tick(); reset = 1;
        tick(); reset = 0;
        @(negedge clk);
        n_checks++; if (a_rd_done !== 1'b0 || a_readdata !== 8'h00) begin n_fail++; $display("[TB] FAIL rst_rd_abandon got %b/%h exp 0/00", a_rd_done, a_readdata); end
        n_checks++; if ({m_read, m_write, b_readdatavalid, b_readdata} !== 11'h0) begin n_fail++; $display("[TB] FAIL rst_rd_outputs got %h exp 000", {m_read, m_write, b_readdatavalid, b_readdata}); end
        tick();
        @(negedge clk);
        n_checks++; if (a_rd_done !== 1'b0 || m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_rd_after got %b/%b exp 0/0", a_rd_done, m_read); end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_a_read();
        test_b_arbitration();
        test_b_inflight();
        test_overrun();
        test_back_to_back();
        test_rw_together();
        test_b_write_wins();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
